apb_master_bridge: RTL and testbench

Initiator end of the team's 64-bit APB fabric. Accepts single read/write commands on a valid/ready request port and runs each as one APB transfer (SETUP then ACCESS). Decodes the address into `cs`/`PSEL1`/`PSEL2` for the four-slave subsystem and returns read data and error status on a response port. It also terminates hung transfers with a PREADY timeout.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_timeout_ctr.sv | 34 +++
 rtl/apb_master_bridge.sv | 143 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
//   apb_state_e : transfer FSM state (idle, setup phase, access phase)
//   SEL_W       : width of the slave-index field decoded from the address
//   SLV_IDX*    : slave-index values of the four-slave subsystem
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SLV_IDX0 = 2'd0;
  localparam logic [SEL_W-1:0] SLV_IDX1 = 2'd1;
  localparam logic [SEL_W-1:0] SLV_IDX2 = 2'd2;
  localparam logic [SEL_W-1:0] SLV_IDX3 = 2'd3;

endpackage

// File: rtl/apb_timeout_ctr.sv
// PREADY timeout counter for the APB access phase.
// Ports:
//   PCLK      : clock, rising edge
//   PRESET    : synchronous active-high reset
//   clear_i   : zero the count (asserted the cycle before ACCESS starts)
//   enable_i  : count this cycle (ACCESS with PREADY low)
//   expired_o : the current ACCESS cycle is the last one allowed without PREADY
module apb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // Saturates at CntMax so a stalled enable can never wrap back to a small count.
  always_ff @(posedge PCLK) begin
    if (PRESET || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired_o = enable_i && (cnt_q == CntMax);

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: turns single valid/ready read/write commands into one APB transfer each
// (SETUP then ACCESS), decodes the slave index into cs/PSEL1/PSEL2 and reports read data
// and error status as a one-cycle response pulse. Hung transfers end after TIMEOUT
// ACCESS cycles without PREADY.
// Ports:
//   PCLK, PRESET                 : clock and synchronous active-high reset
//   cmd_valid/cmd_ready          : request handshake (cmd_ready is combinational on PREADY)
//   cmd_write/cmd_addr/cmd_wdata : request contents
//   rsp_valid/rsp_rdata/rsp_err  : completion pulse, read data, slave error or timeout
//   cs, PSEL1, PSEL2             : subsystem select and slave index bits [1]/[0]
//   PENABLE/PWRITE/PADDR/PWDATA  : APB request signals (registered)
//   PRDATA/PREADY/slverr         : OR-combined slave returns
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned SEL_LSB = 62,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              cs,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              slverr
);

  apb_state_e        state_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              cs_q;
  logic              psel1_q;
  logic              psel2_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;

  logic             accept;
  logic             expired;
  logic             ctr_clear;
  logic             ctr_enable;
  logic [SEL_W-1:0] idx;

  // Ready in ACCESS only when the current transfer completes normally, which lets the
  // next command go straight to SETUP; a timeout never accepts.
  assign cmd_ready  = (state_q == StIdle) || ((state_q == StAccess) && PREADY);
  assign accept     = cmd_valid && cmd_ready;
  assign idx        = cmd_addr[SEL_LSB +: SEL_W];
  assign ctr_clear  = (state_q == StSetup);
  assign ctr_enable = (state_q == StAccess) && !PREADY;

  apb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .clear_i   (ctr_clear),
    .enable_i  (ctr_enable),
    .expired_o (expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cs_q        <= 1'b0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
        end
        StAccess: begin
          // PREADY takes priority over a timeout landing in the same cycle.
          if (PREADY || expired) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= PREADY ? slverr : 1'b1;
            rsp_rdata_q <= (PREADY && !pwrite_q) ? PRDATA : '0;
            state_q     <= StIdle;
            cs_q        <= 1'b0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
      // Placed last so a back-to-back accept overrides the return to idle above.
      if (accept) begin
        state_q   <= StSetup;
        cs_q      <= 1'b1;
        psel1_q   <= idx[1];
        psel2_q   <= idx[0];
        penable_q <= 1'b0;
        pwrite_q  <= cmd_write;
        paddr_q   <= cmd_addr;
        pwdata_q  <= cmd_wdata;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign cs        = cs_q;
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: table of directed transfers, hand-written
// back-to-back and reset-abort sequences, then randomized transfers scored by a
// transaction-level model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned SEL_LSB = 62;
  localparam int          TO      = 16;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              cs;
  logic              PSEL1;
  logic              PSEL2;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              slverr;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SEL_LSB (SEL_LSB),
    .TIMEOUT (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .cs        (cs),
    .PSEL1     (PSEL1),
    .PSEL2     (PSEL2),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .slverr    (slverr)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          waits;     // ACCESS cycles before PREADY; >= TO means never in time
    logic [63:0] prdata;
    logic        serr;
    logic [1:0]  exp_sel;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;   // edges from accept to rsp_valid visible
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Transaction-level outcome: a transfer either sees PREADY within TO access cycles
  // or is cut off after exactly TO of them.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   to;
    r           = v;
    to          = (v.waits >= TO);
    r.exp_sel   = v.addr[SEL_LSB +: 2];
    r.exp_err   = to ? 1'b1 : v.serr;
    r.exp_rdata = (to || v.wr) ? 64'd0 : v.prdata;
    r.exp_lat   = 3 + (to ? (TO - 1) : v.waits);
    return r;
  endfunction

  // Called one step after a rising edge with the bridge idle.
  task automatic do_txn(input vec_t v, input string tag);
    int lat;
    int k;
    bit done;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    #1 chk({tag, ".ready_idle"}, cmd_ready, 1);
    tick();
    lat       = 1;
    cmd_valid = 1'b0;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    chk({tag, ".setup_cs"}, cs, 1);
    chk({tag, ".setup_penable"}, PENABLE, 0);
    chk({tag, ".setup_psel1"}, PSEL1, v.exp_sel[1]);
    chk({tag, ".setup_psel2"}, PSEL2, v.exp_sel[0]);
    chk({tag, ".setup_pwrite"}, PWRITE, v.wr);
    chk({tag, ".setup_paddr"}, PADDR, v.addr);
    chk({tag, ".setup_pwdata"}, PWDATA, v.wdata);
    chk({tag, ".setup_ready"}, cmd_ready, 0);
    tick();
    lat = 2;
    chk({tag, ".access_penable"}, PENABLE, 1);
    chk({tag, ".access_cs"}, cs, 1);
    k    = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      PREADY = (k == v.waits);
      PRDATA = PREADY ? v.prdata : ~v.prdata;
      slverr = PREADY ? v.serr : ~v.serr;
      #1 chk({tag, ".access_ready"}, cmd_ready, PREADY);
      tick();
      lat++;
      PREADY = 1'b0;
      slverr = 1'b0;
      if (rsp_valid) done = 1'b1;
      else k++;
    end
    chk({tag, ".completed"}, done, 1);
    chk({tag, ".latency"}, 64'(lat), 64'(v.exp_lat));
    chk({tag, ".rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, ".err"}, rsp_err, v.exp_err);
    chk({tag, ".idle_cs"}, {cs, PSEL1, PSEL2, PENABLE}, 0);
    chk({tag, ".idle_paddr_hold"}, PADDR, v.addr);
    tick();
    chk({tag, ".rsp_pulse"}, rsp_valid, 0);
    chk({tag, ".rdata_hold"}, rsp_rdata, v.exp_rdata);
    chk({tag, ".err_hold"}, rsp_err, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    slverr    = 1'b0;

    vecs[0] = '{wr: 1'b1, addr: 64'h4000_0000_0000_0010, wdata: 64'hDEAD_BEEF, waits: 0,
                prdata: 64'h5555, serr: 1'b0, exp_sel: SLV_IDX1, exp_rdata: 64'h0,
                exp_err: 1'b0, exp_lat: 3};
    vecs[1] = '{wr: 1'b0, addr: 64'hC000_0000_0000_0008, wdata: 64'h0, waits: 3,
                prdata: 64'h1234, serr: 1'b1, exp_sel: SLV_IDX3, exp_rdata: 64'h1234,
                exp_err: 1'b1, exp_lat: 6};
    vecs[2] = '{wr: 1'b0, addr: 64'h0000_0000_0000_0100, wdata: 64'h0, waits: 100,
                prdata: 64'h9999, serr: 1'b0, exp_sel: SLV_IDX0, exp_rdata: 64'h0,
                exp_err: 1'b1, exp_lat: 18};
    vecs[3] = '{wr: 1'b0, addr: 64'h8000_0000_0000_0040, wdata: 64'h0, waits: 15,
                prdata: 64'hABCD, serr: 1'b0, exp_sel: SLV_IDX2, exp_rdata: 64'hABCD,
                exp_err: 1'b0, exp_lat: 18};
    vecs[4] = '{wr: 1'b1, addr: 64'h8000_0000_0000_0080, wdata: 64'h0123_4567_89AB_CDEF,
                waits: 14, prdata: 64'h7777, serr: 1'b1, exp_sel: SLV_IDX2,
                exp_rdata: 64'h0, exp_err: 1'b1, exp_lat: 17};
    vecs[5] = '{wr: 1'b0, addr: 64'h4000_0000_0000_0000, wdata: 64'h0, waits: 0,
                prdata: 64'hFFFF_0000_1111_2222, serr: 1'b0, exp_sel: SLV_IDX1,
                exp_rdata: 64'hFFFF_0000_1111_2222, exp_err: 1'b0, exp_lat: 3};

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst.ready", cmd_ready, 1);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_err", rsp_err, 0);
    chk("rst.rsp_rdata", rsp_rdata, 0);
    chk("rst.bus_ctl", {cs, PSEL1, PSEL2, PENABLE, PWRITE}, 0);
    chk("rst.paddr", PADDR, 0);
    chk("rst.pwdata", PWDATA, 0);
    PRESET = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: second command held valid through the first transfer
    cmd_write = 1'b1;
    cmd_addr  = 64'h4000_0000_0000_0018;
    cmd_wdata = 64'h1111;
    cmd_valid = 1'b1;
    tick();                                     // SETUP A
    cmd_write = 1'b0;
    cmd_addr  = 64'h8000_0000_0000_0020;
    chk("b2b.setupA_ready", cmd_ready, 0);
    chk("b2b.setupA_cs", cs, 1);
    chk("b2b.setupA_penable", PENABLE, 0);
    tick();                                     // ACCESS A, completes
    PREADY = 1'b1;
    PRDATA = 64'h2222;
    #1 chk("b2b.accessA_ready", cmd_ready, 1);
    chk("b2b.accessA_cs", cs, 1);
    chk("b2b.accessA_penable", PENABLE, 1);
    tick();                                     // SETUP B, response A
    PREADY    = 1'b0;
    cmd_valid = 1'b0;
    chk("b2b.rspA_valid", rsp_valid, 1);
    chk("b2b.rspA_rdata", rsp_rdata, 0);
    chk("b2b.rspA_err", rsp_err, 0);
    chk("b2b.setupB_cs", cs, 1);
    chk("b2b.setupB_penable", PENABLE, 0);
    chk("b2b.setupB_paddr", PADDR, 64'h8000_0000_0000_0020);
    chk("b2b.setupB_sel", {PSEL1, PSEL2, PWRITE}, 3'b100);
    chk("b2b.setupB_ready", cmd_ready, 0);
    tick();                                     // ACCESS B
    PREADY = 1'b1;
    PRDATA = 64'h77;
    #1 chk("b2b.accessB_ready", cmd_ready, 1);
    chk("b2b.accessB_cs", cs, 1);
    chk("b2b.accessB_rsp", rsp_valid, 0);
    tick();                                     // response B
    PREADY = 1'b0;
    chk("b2b.rspB_valid", rsp_valid, 1);
    chk("b2b.rspB_rdata", rsp_rdata, 64'h77);
    chk("b2b.rspB_cs", cs, 0);
    chk("b2b.rspB_ready", cmd_ready, 1);
    tick();

    // Reset during ACCESS aborts with no response, even with PREADY high
    cmd_write = 1'b1;
    cmd_addr  = 64'hC000_0000_0000_0030;
    cmd_wdata = 64'h4444;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rstmid.in_access", PENABLE, 1);
    PRESET = 1'b1;
    PREADY = 1'b1;
    PRDATA = 64'h5A5A;
    tick();
    PRESET = 1'b0;
    PREADY = 1'b0;
    chk("rstmid.bus_ctl", {cs, PSEL1, PSEL2, PENABLE, PWRITE}, 0);
    chk("rstmid.paddr", PADDR, 0);
    chk("rstmid.pwdata", PWDATA, 0);
    chk("rstmid.ready", cmd_ready, 1);
    chk("rstmid.rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid.no_rsp", rsp_valid, 0);
    end

    // Randomized transfers against the transaction model
    for (int i = 0; i < 40; i++) begin
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = {$urandom, $urandom};
      v.wdata  = {$urandom, $urandom};
      v.waits  = int'($urandom_range(0, 20));
      v.prdata = {$urandom, $urandom};
      v.serr   = 1'($urandom_range(0, 1));
      v        = model(v);
      do_txn(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
